// File: rtl/mcse_def.sv
// ============================================================================
// Module : mcse_def (package)
// Brief  : Shared boot-sequencer types, fail-count width and address defines.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef SECURE_MEMORY_WIDTH
`define SECURE_MEMORY_WIDTH 32
`endif
`ifndef SECURE_MEMORY_LENGTH
`define SECURE_MEMORY_LENGTH 64
`endif
`ifndef FW_FAIL_CNT_ADDR
`define FW_FAIL_CNT_ADDR 5
`endif
`ifndef CPU_RELEASE_ADDR
`define CPU_RELEASE_ADDR 32'h4000_0010
`endif

package mcse_def;

    localparam int FAIL_CNT_W = 8;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        RD_CNT   = 4'd1,
        CHECK    = 4'd2,
        AUTH     = 4'd3,
        AUTH_ACK = 4'd4,
        WR_CNT   = 4'd5,
        RELEASE  = 4'd6,
        DONE     = 4'd7,
        LOCKED   = 4'd8
    } boot_state_t;

    // A pass clears the persistent count; a failure bumps it, pinned at all-ones.
    function automatic logic [FAIL_CNT_W-1:0] fail_cnt_next(
        input logic [FAIL_CNT_W-1:0] cnt,
        input logic                  pass
    );
        if (pass)
            return '0;
        else if (cnt == {FAIL_CNT_W{1'b1}})
            return cnt;
        else
            return cnt + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fw_boot_sequencer_if.sv
// ============================================================================
// Module : fw_boot_sequencer_if
// Brief  : Authentication, secure-memory and bus handshake bundle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fw_boot_sequencer_if #(
    parameter int pAHB_ADDR_WIDTH    = 32,
    parameter int pPAYLOAD_SIZE_BITS = 128,
    parameter int memory_width       = 32,
    parameter int memory_length      = 64
) ();
    localparam int c_addr_w = $clog2(memory_length);

    logic                          fw_auth_done;
    logic                          fw_auth_result;
    logic                          fw_authentication_trigger;
    logic [memory_width-1:0]       rdData;
    logic                          rdData_valid;
    logic                          seq_rd_en;
    logic                          seq_wr_en;
    logic [c_addr_w-1:0]           seq_addr;
    logic [memory_width-1:0]       seq_wrData;
    logic                          seq_bus_go;
    logic [pAHB_ADDR_WIDTH-1:0]    seq_bus_addr;
    logic [pPAYLOAD_SIZE_BITS-1:0] seq_bus_write;
    logic                          seq_bus_RW;
    logic                          bus_done;

    modport master (
        input  fw_auth_done, fw_auth_result, rdData, rdData_valid, bus_done,
        output fw_authentication_trigger, seq_rd_en, seq_wr_en, seq_addr,
               seq_wrData, seq_bus_go, seq_bus_addr, seq_bus_write, seq_bus_RW
    );

    modport slave (
        output fw_auth_done, fw_auth_result, rdData, rdData_valid, bus_done,
        input  fw_authentication_trigger, seq_rd_en, seq_wr_en, seq_addr,
               seq_wrData, seq_bus_go, seq_bus_addr, seq_bus_write, seq_bus_RW
    );
endinterface

`default_nettype wire

// File: rtl/fw_auth_watchdog.sv
// ============================================================================
// Module : fw_auth_watchdog
// Brief  : Authentication timeout counter; built only with FW_BOOT_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef FW_BOOT_TIMEOUT_EN
module fw_auth_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en,
    output logic      timeout
);
    localparam int                c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Counter restarts whenever the sequencer leaves AUTH, so each retry gets a full window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (!en)
            r_cnt <= '0;
        else if (r_cnt != c_last)
            r_cnt <= r_cnt + 1'b1;
    end

    assign timeout = en && (r_cnt == c_last);
endmodule
`endif

`default_nettype wire

// File: rtl/fw_boot_sequencer.sv
// ============================================================================
// Module : fw_boot_sequencer
// Brief  : Secure boot sequencer with persistent fail count and CPU release.
//          Optional auth watchdog enabled by macro FW_BOOT_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef SECURE_MEMORY_WIDTH
`define SECURE_MEMORY_WIDTH 32
`endif
`ifndef SECURE_MEMORY_LENGTH
`define SECURE_MEMORY_LENGTH 64
`endif
`ifndef FW_FAIL_CNT_ADDR
`define FW_FAIL_CNT_ADDR 5
`endif
`ifndef CPU_RELEASE_ADDR
`define CPU_RELEASE_ADDR 32'h4000_0010
`endif

module fw_boot_sequencer
    import mcse_def::*;
#(
    parameter int                         pAHB_ADDR_WIDTH    = 32,
    parameter int                         pPAYLOAD_SIZE_BITS = 128,
    parameter int                         memory_width       = `SECURE_MEMORY_WIDTH,
    parameter int                         memory_length      = `SECURE_MEMORY_LENGTH,
    parameter int                         MAX_ATTEMPTS       = 3,
    parameter int                         FAIL_CNT_ADDR      = `FW_FAIL_CNT_ADDR,
    parameter logic [pAHB_ADDR_WIDTH-1:0] CPU_RELEASE_ADDR   = `CPU_RELEASE_ADDR,
    parameter int                         TIMEOUT_CYCLES     = 4096
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              boot_start,
    fw_boot_sequencer_if.master    sif,
    output logic                   boot_done,
    output logic                   boot_pass,
    output logic                   boot_lockout
);
    localparam int                     c_addr_w   = $clog2(memory_length);
    localparam logic [c_addr_w-1:0]    c_cnt_addr = c_addr_w'(FAIL_CNT_ADDR);
    localparam logic [FAIL_CNT_W-1:0]  c_max      = FAIL_CNT_W'(MAX_ATTEMPTS);

    boot_state_t                   r_state, w_state_nxt;
    logic [FAIL_CNT_W-1:0]         r_fail_cnt, w_cnt_nxt;
    logic                          r_result, w_result_nxt;
    logic                          r_trig, w_trig_nxt;
    logic                          r_rd_en, w_rd_en_nxt;
    logic                          r_wr_en, w_wr_en_nxt;
    logic [c_addr_w-1:0]           r_addr, w_addr_nxt;
    logic [memory_width-1:0]       r_wr_data, w_wr_data_nxt;
    logic                          r_bus_go, w_bus_go_nxt;
    logic [pAHB_ADDR_WIDTH-1:0]    r_bus_addr, w_bus_addr_nxt;
    logic [pPAYLOAD_SIZE_BITS-1:0] r_bus_write, w_bus_write_nxt;
    logic                          r_bus_rw, w_bus_rw_nxt;
    logic                          r_done, w_done_nxt;
    logic                          r_pass, w_pass_nxt;
    logic                          r_lock, w_lock_nxt;

`ifdef FW_BOOT_TIMEOUT_EN
    logic w_timeout;

    fw_auth_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (r_state == AUTH),
        .timeout (w_timeout)
    );
`endif

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_fail_cnt;
        w_result_nxt    = r_result;
        w_trig_nxt      = 1'b0;
        w_rd_en_nxt     = 1'b0;
        w_wr_en_nxt     = 1'b0;
        w_addr_nxt      = '0;
        w_wr_data_nxt   = '0;
        w_bus_go_nxt    = 1'b0;
        w_bus_addr_nxt  = '0;
        w_bus_write_nxt = '0;
        w_bus_rw_nxt    = 1'b0;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = 1'b0;
        w_lock_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (boot_start) begin
                    w_state_nxt = RD_CNT;
                    w_rd_en_nxt = 1'b1;
                    w_addr_nxt  = c_cnt_addr;
                end
            end
            RD_CNT: begin
                if (sif.rdData_valid) begin
                    w_cnt_nxt   = sif.rdData[FAIL_CNT_W-1:0];
                    w_state_nxt = CHECK;
                end else begin
                    w_rd_en_nxt = 1'b1;
                    w_addr_nxt  = c_cnt_addr;
                end
            end
            CHECK: begin
                if (r_fail_cnt >= c_max) begin
                    w_state_nxt = LOCKED;
                    w_done_nxt  = 1'b1;
                    w_lock_nxt  = 1'b1;
                end else begin
                    w_state_nxt = AUTH;
                    w_trig_nxt  = 1'b1;
                end
            end
            AUTH: begin
                if (sif.fw_auth_done) begin
                    w_result_nxt = sif.fw_auth_result;
                    w_state_nxt  = AUTH_ACK;
                end
`ifdef FW_BOOT_TIMEOUT_EN
                else if (w_timeout) begin
                    w_result_nxt                    = 1'b0;
                    w_cnt_nxt                       = fail_cnt_next(r_fail_cnt, 1'b0);
                    w_state_nxt                     = WR_CNT;
                    w_wr_en_nxt                     = 1'b1;
                    w_addr_nxt                      = c_cnt_addr;
                    w_wr_data_nxt[FAIL_CNT_W-1:0]   = w_cnt_nxt;
                end
`endif
                else begin
                    w_trig_nxt = 1'b1;
                end
            end
            AUTH_ACK: begin
                if (!sif.fw_auth_done) begin
                    w_cnt_nxt                     = fail_cnt_next(r_fail_cnt, r_result);
                    w_state_nxt                   = WR_CNT;
                    w_wr_en_nxt                   = 1'b1;
                    w_addr_nxt                    = c_cnt_addr;
                    w_wr_data_nxt[FAIL_CNT_W-1:0] = w_cnt_nxt;
                end
            end
            WR_CNT: begin
                if (r_result) begin
                    w_state_nxt        = RELEASE;
                    w_bus_go_nxt       = 1'b1;
                    w_bus_addr_nxt     = CPU_RELEASE_ADDR;
                    w_bus_rw_nxt       = 1'b1;
                    w_bus_write_nxt[0] = 1'b1;
                end else if (r_fail_cnt >= c_max) begin
                    w_state_nxt = LOCKED;
                    w_done_nxt  = 1'b1;
                    w_lock_nxt  = 1'b1;
                end else begin
                    w_state_nxt = AUTH;
                    w_trig_nxt  = 1'b1;
                end
            end
            RELEASE: begin
                if (sif.bus_done) begin
                    w_state_nxt = DONE;
                    w_done_nxt  = 1'b1;
                    w_pass_nxt  = 1'b1;
                end else begin
                    w_bus_addr_nxt     = CPU_RELEASE_ADDR;
                    w_bus_rw_nxt       = 1'b1;
                    w_bus_write_nxt[0] = 1'b1;
                end
            end
            DONE: begin
                w_done_nxt = 1'b1;
                w_pass_nxt = 1'b1;
            end
            LOCKED: begin
                w_done_nxt = 1'b1;
                w_lock_nxt = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_fail_cnt  <= '0;
            r_result    <= 1'b0;
            r_trig      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_bus_go    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_write <= '0;
            r_bus_rw    <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_lock      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_fail_cnt  <= w_cnt_nxt;
            r_result    <= w_result_nxt;
            r_trig      <= w_trig_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_addr      <= w_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_bus_go    <= w_bus_go_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_write <= w_bus_write_nxt;
            r_bus_rw    <= w_bus_rw_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_lock      <= w_lock_nxt;
        end
    end

    assign sif.fw_authentication_trigger = r_trig;
    assign sif.seq_rd_en                 = r_rd_en;
    assign sif.seq_wr_en                 = r_wr_en;
    assign sif.seq_addr                  = r_addr;
    assign sif.seq_wrData                = r_wr_data;
    assign sif.seq_bus_go                = r_bus_go;
    assign sif.seq_bus_addr              = r_bus_addr;
    assign sif.seq_bus_write             = r_bus_write;
    assign sif.seq_bus_RW                = r_bus_rw;
    assign boot_done                     = r_done;
    assign boot_pass                     = r_pass;
    assign boot_lockout                  = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_fw_boot_sequencer.sv
// ============================================================================
// Module : tb_fw_boot_sequencer
// Brief  : Directed self-checking bench for fw_boot_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fw_boot_sequencer;
    localparam int          c_aw      = 32;
    localparam int          c_pw      = 128;
    localparam int          c_mw      = 32;
    localparam int          c_ml      = 64;
    localparam int          c_max     = 3;
    localparam int          c_cnt_adr = 5;
    localparam logic [31:0] c_cpu_adr = 32'h4000_0010;
    localparam int          c_tmo     = 4096;

    logic clk;
    logic rst_n;
    logic boot_start;
    logic boot_done, boot_pass, boot_lockout;

    int n_checks = 0;
    int n_fail   = 0;

    // memory / bus / trigger observation state, owned by the responder process
    logic [7:0]      stored_cnt;
    logic [c_mw-1:0] wr_log [0:15];
    logic [5:0]      wr_adr_log [0:15];
    int              wr_n, wr_multi, rd_wait;
    logic            prev_wr;
    int              bus_n, bus_cd;
    logic [31:0]     bus_adr_seen;
    logic [c_pw-1:0] bus_data_seen;
    logic            bus_rw_seen;
    int              trig_rises, trig_run, trig_last_run;
    logic            prev_trig;

    fw_boot_sequencer_if #(
        .pAHB_ADDR_WIDTH    (c_aw),
        .pPAYLOAD_SIZE_BITS (c_pw),
        .memory_width       (c_mw),
        .memory_length      (c_ml)
    ) sif ();

    fw_boot_sequencer #(
        .pAHB_ADDR_WIDTH    (c_aw),
        .pPAYLOAD_SIZE_BITS (c_pw),
        .memory_width       (c_mw),
        .memory_length      (c_ml),
        .MAX_ATTEMPTS       (c_max),
        .FAIL_CNT_ADDR      (c_cnt_adr),
        .CPU_RELEASE_ADDR   (c_cpu_adr),
        .TIMEOUT_CYCLES     (c_tmo)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .boot_start   (boot_start),
        .sif          (sif),
        .boot_done    (boot_done),
        .boot_pass    (boot_pass),
        .boot_lockout (boot_lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder: memory with 2-cycle read latency, bus with 2-cycle completion, trigger monitor.
    initial begin
        sif.rdData_valid = 1'b0;
        sif.rdData       = '0;
        sif.bus_done     = 1'b0;
        forever begin
            @(negedge clk);
            sif.rdData_valid = 1'b0;
            sif.bus_done     = 1'b0;
            rd_wait = sif.seq_rd_en ? rd_wait + 1 : 0;
            if (rd_wait == 2) begin
                sif.rdData_valid = 1'b1;
                sif.rdData       = {24'hA5C35A, stored_cnt};
            end
            if (sif.seq_wr_en) begin
                if (prev_wr) wr_multi++;
                stored_cnt = sif.seq_wrData[7:0];
                if (wr_n < 16) begin
                    wr_log[wr_n]     = sif.seq_wrData;
                    wr_adr_log[wr_n] = sif.seq_addr;
                end
                wr_n++;
            end
            prev_wr = sif.seq_wr_en;
            if (sif.seq_bus_go) begin
                bus_n++;
                bus_adr_seen  = sif.seq_bus_addr;
                bus_data_seen = sif.seq_bus_write;
                bus_rw_seen   = sif.seq_bus_RW;
                bus_cd        = 2;
            end else if (bus_cd > 0) begin
                bus_cd--;
                if (bus_cd == 0) sif.bus_done = 1'b1;
            end
            if (sif.fw_authentication_trigger) begin
                if (!prev_trig) trig_rises++;
                trig_run++;
            end else if (prev_trig) begin
                trig_last_run = trig_run;
                trig_run      = 0;
            end
            prev_trig = sif.fw_authentication_trigger;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] cnt);
        rst_n              = 1'b0;
        boot_start         = 1'b0;
        sif.fw_auth_done   = 1'b0;
        sif.fw_auth_result = 1'b0;
        #1;
        check("reset_outputs",
              {sif.fw_authentication_trigger, sif.seq_rd_en, sif.seq_wr_en, sif.seq_bus_go,
               sif.seq_bus_RW, boot_done, boot_pass, boot_lockout}, 8'h00);
        step();
        stored_cnt = cnt;  wr_n = 0;  wr_multi = 0;  rd_wait = 0;  prev_wr = 1'b0;
        bus_n = 0;  bus_cd = 0;  trig_rises = 0;  trig_run = 0;  trig_last_run = 0;
        prev_trig = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_boot();
        boot_start = 1'b1;
        step();
        boot_start = 1'b0;
    endtask

    task automatic wait_trig(input int bound);
        for (int i = 0; i < bound && !sif.fw_authentication_trigger; i++) step();
        check("trigger_seen", sif.fw_authentication_trigger, 1'b1);
    endtask

    // Answer one authentication request; done stays high for 'hold' cycles.
    task automatic auth_respond(input logic result, input int hold);
        wait_trig(60);
        sif.fw_auth_done   = 1'b1;
        sif.fw_auth_result = result;
        for (int i = 0; i < hold; i++) begin
            step();
            check("trigger_low_while_done", sif.fw_authentication_trigger, 1'b0);
        end
        sif.fw_auth_done   = 1'b0;
        sif.fw_auth_result = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !boot_done; i++) step();
        check("boot_done_reached", boot_done, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        boot_start = 1'b0;
        sif.fw_auth_done = 1'b0;
        sif.fw_auth_result = 1'b0;

        // stored 0, pass with done held 5 cycles
        do_reset(8'd0);
        check("idle_no_read", sif.seq_rd_en, 1'b0);
        start_boot();
        auth_respond(1'b1, 5);
        wait_done(40);
        check("s1_writes", wr_n, 1);
        check("s1_wr_val", wr_log[0], 32'd0);
        check("s1_wr_adr", wr_adr_log[0], 6'd5);
        check("s1_bus_n", bus_n, 1);
        check("s1_bus_adr", bus_adr_seen, c_cpu_adr);
        check("s1_bus_data", bus_data_seen, 128'd1);
        check("s1_bus_rw", bus_rw_seen, 1'b1);
        check("s1_status", {boot_done, boot_pass, boot_lockout}, 3'b110);
        check("s1_trig_rises", trig_rises, 1);
        // boot_start in DONE is ignored
        boot_start = 1'b1;
        repeat (4) step();
        boot_start = 1'b0;
        check("s1_done_ignore_start", {sif.seq_rd_en, boot_done, boot_pass}, 3'b011);

        // stored 0, three failures -> lockout
        do_reset(8'd0);
        start_boot();
        auth_respond(1'b0, 1);
        auth_respond(1'b0, 1);
        auth_respond(1'b0, 1);
        wait_done(40);
        check("s2_writes", wr_n, 3);
        check("s2_wr0", wr_log[0], 32'd1);
        check("s2_wr1", wr_log[1], 32'd2);
        check("s2_wr2", wr_log[2], 32'd3);
        check("s2_wr_single_cycle", wr_multi, 0);
        check("s2_bus_n", bus_n, 0);
        check("s2_status", {boot_done, boot_pass, boot_lockout}, 3'b101);
        repeat (6) step();
        check("s2_locked_quiet", {sif.seq_rd_en, sif.seq_wr_en, sif.seq_bus_go,
                                  sif.fw_authentication_trigger}, 4'h0);
        check("s2_locked_no_writes", wr_n, 3);

        // stored 3 -> immediate lockout
        do_reset(8'd3);
        start_boot();
        wait_done(40);
        check("s3_status", {boot_done, boot_pass, boot_lockout}, 3'b101);
        check("s3_no_trigger", trig_rises, 0);
        check("s3_no_write", wr_n, 0);
        check("s3_no_bus", bus_n, 0);

        // stored 1, fail then pass
        do_reset(8'd1);
        start_boot();
        auth_respond(1'b0, 1);
        auth_respond(1'b1, 1);
        wait_done(40);
        check("s4_writes", wr_n, 2);
        check("s4_wr0", wr_log[0], 32'd2);
        check("s4_wr1", wr_log[1], 32'd0);
        check("s4_bus_n", bus_n, 1);
        check("s4_status", {boot_done, boot_pass, boot_lockout}, 3'b110);

        // asynchronous reset mid-authentication aborts at once
        do_reset(8'd0);
        start_boot();
        wait_trig(60);
        rst_n = 1'b0;
        #1;
        check("s5_async_abort", {sif.fw_authentication_trigger, boot_done}, 2'b00);
        check("s5_no_write", wr_n, 0);

`ifdef FW_BOOT_TIMEOUT_EN
        // no done for the full watchdog window -> failed attempt and retry
        do_reset(8'd0);
        start_boot();
        wait_trig(60);
        for (int i = 0; i < c_tmo + 100 && wr_n == 0; i++) step();
        check("s6_timeout_write", wr_n, 1);
        check("s6_timeout_val", wr_log[0], 32'd1);
        check("s6_trigger_window", trig_last_run, c_tmo);
        repeat (3) step();
        check("s6_retry_trigger", sif.fw_authentication_trigger, 1'b1);
        check("s6_trig_rises", trig_rises, 2);
        auth_respond(1'b1, 1);
        wait_done(40);
        check("s6_status", {boot_done, boot_pass, boot_lockout}, 3'b110);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
